// File: rtl/core_branch_predictor_pkg.sv
// Shared types and widths for the fetch-side branch predictor.
package core_branch_predictor_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int BP_INDEX_WIDTH = 6;
  localparam int BP_TAG_WIDTH   = DATA_WIDTH - BP_INDEX_WIDTH - 2;
  localparam int BP_ENTRIES     = 1 << BP_INDEX_WIDTH;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } bp_counter_t;

endpackage

// File: rtl/core_branch_predictor_sat_counter.sv
// Next-state function of a 2-bit saturating branch counter.
module core_sat_counter
  import core_branch_predictor_pkg::*;
(
  input  bp_counter_t counter_in,
  input  logic        taken,
  output bp_counter_t counter_out
);

  always_comb begin
    counter_out = counter_in;
    if (taken) begin
      if (counter_in != STRONG_T) counter_out = bp_counter_t'(counter_in + 2'd1);
    end else begin
      if (counter_in != STRONG_NT) counter_out = bp_counter_t'(counter_in - 2'd1);
    end
  end

endmodule

// File: rtl/core_branch_predictor.sv
// Direct-mapped BHT with tagged BTB; registered prediction one cycle after lookup.
module core_branch_predictor
  import core_branch_predictor_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_valid,
  input  logic                  fetch_stall,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  output logic                  predict_valid,
  output logic                  predict_taken,
  output logic                  predict_hit,
  output logic [DATA_WIDTH-1:0] predict_target,
  input  logic                  update_valid,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target
);

  logic                    valid_q  [BP_ENTRIES];
  logic [BP_TAG_WIDTH-1:0] tag_q    [BP_ENTRIES];
  logic [DATA_WIDTH-1:0]   target_q [BP_ENTRIES];
  bp_counter_t             ctr_q    [BP_ENTRIES];

  logic [BP_INDEX_WIDTH-1:0] upd_idx, fet_idx;
  logic [BP_TAG_WIDTH-1:0]   upd_tag, fet_tag;
  logic                      upd_hit, upd_we;
  bp_counter_t               upd_ctr_next;

  logic                    new_valid;
  logic [BP_TAG_WIDTH-1:0] new_tag;
  logic [DATA_WIDTH-1:0]   new_target;
  bp_counter_t             new_ctr;

  logic                    lk_valid;
  logic [BP_TAG_WIDTH-1:0] lk_tag;
  logic [DATA_WIDTH-1:0]   lk_target;
  bp_counter_t             lk_ctr;
  logic                    lk_hit;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  assign upd_idx = update_pc[BP_INDEX_WIDTH+1:2];
  assign upd_tag = update_pc[DATA_WIDTH-1:BP_INDEX_WIDTH+2];
  assign fet_idx = fetch_pc[BP_INDEX_WIDTH+1:2];
  assign fet_tag = fetch_pc[DATA_WIDTH-1:BP_INDEX_WIDTH+2];

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  // A not-taken miss never allocates, so it writes nothing.
  assign upd_we  = update_valid && (upd_hit || update_taken);

  core_sat_counter u_sat_counter (
    .counter_in  (ctr_q[upd_idx]),
    .taken       (update_taken),
    .counter_out (upd_ctr_next)
  );

  always_comb begin
    new_valid  = 1'b1;
    new_tag    = upd_tag;
    new_target = update_target;
    new_ctr    = WEAK_T;
    if (upd_hit) begin
      new_ctr = upd_ctr_next;
      if (!update_taken) new_target = target_q[upd_idx];
    end
  end

  // Write-first bypass: a lookup to the index being trained sees the new entry.
  always_comb begin
    lk_valid  = valid_q[fet_idx];
    lk_tag    = tag_q[fet_idx];
    lk_target = target_q[fet_idx];
    lk_ctr    = ctr_q[fet_idx];
    if (upd_we && (upd_idx == fet_idx)) begin
      lk_valid  = new_valid;
      lk_tag    = new_tag;
      lk_target = new_target;
      lk_ctr    = new_ctr;
    end
    lk_hit = lk_valid && (lk_tag == fet_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BP_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WEAK_NT;
      end
    end else if (upd_we) begin
      valid_q[upd_idx]  <= new_valid;
      tag_q[upd_idx]    <= new_tag;
      target_q[upd_idx] <= new_target;
      ctr_q[upd_idx]    <= new_ctr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      predict_valid  <= 1'b0;
      predict_taken  <= 1'b0;
      predict_hit    <= 1'b0;
      predict_target <= '0;
    end else if (!fetch_stall) begin
      predict_valid  <= fetch_valid;
      predict_hit    <= fetch_valid && lk_hit;
      predict_taken  <= fetch_valid && lk_hit && lk_ctr[1];
      predict_target <= (fetch_valid && lk_hit) ? lk_target : '0;
    end
  end

endmodule

// File: tb/tb_core_branch_predictor.sv
// Directed plan plus randomized traffic checked against a behavioural table model.
module tb_core_branch_predictor;
  import core_branch_predictor_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst, fetch_valid, fetch_stall, update_valid, update_taken;
  logic [DATA_WIDTH-1:0] fetch_pc, update_pc, update_target;
  logic                  predict_valid, predict_taken, predict_hit;
  logic [DATA_WIDTH-1:0] predict_target;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: entries as plain arrays, counter as an integer 0..3.
  bit                    m_valid [BP_ENTRIES];
  logic [BP_TAG_WIDTH-1:0] m_tag [BP_ENTRIES];
  logic [DATA_WIDTH-1:0] m_tgt   [BP_ENTRIES];
  int                    m_ctr   [BP_ENTRIES];
  bit                    p_valid, p_hit, p_taken;
  logic [DATA_WIDTH-1:0] p_target;

  always #5 clk = ~clk;

  core_branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .fetch_stall    (fetch_stall),
    .fetch_pc       (fetch_pc),
    .predict_valid  (predict_valid),
    .predict_taken  (predict_taken),
    .predict_hit    (predict_hit),
    .predict_target (predict_target),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_target  (update_target)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic int idx_of(input logic [DATA_WIDTH-1:0] pc);
    return int'(pc[BP_INDEX_WIDTH+1:2]);
  endfunction

  function automatic logic [BP_TAG_WIDTH-1:0] tag_of(input logic [DATA_WIDTH-1:0] pc);
    return pc[DATA_WIDTH-1:BP_INDEX_WIDTH+2];
  endfunction

  task automatic model_edge();
    int  i;
    bit  h;
    if (rst) begin
      for (int k = 0; k < BP_ENTRIES; k++) begin
        m_valid[k] = 0; m_tag[k] = '0; m_tgt[k] = '0; m_ctr[k] = 1;
      end
      p_valid = 0; p_hit = 0; p_taken = 0; p_target = '0;
      return;
    end
    if (update_valid) begin
      i = idx_of(update_pc);
      h = m_valid[i] && (m_tag[i] == tag_of(update_pc));
      if (h && update_taken) begin
        m_ctr[i] = (m_ctr[i] >= 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = update_target;
      end else if (h) begin
        m_ctr[i] = (m_ctr[i] <= 0) ? 0 : m_ctr[i] - 1;
      end else if (update_taken) begin
        m_valid[i] = 1; m_tag[i] = tag_of(update_pc); m_tgt[i] = update_target; m_ctr[i] = 2;
      end
    end
    if (!fetch_stall) begin
      i = idx_of(fetch_pc);
      h = fetch_valid && m_valid[i] && (m_tag[i] == tag_of(fetch_pc));
      p_valid  = fetch_valid;
      p_hit    = h;
      p_taken  = h && (m_ctr[i] >= 2);
      p_target = h ? m_tgt[i] : '0;
    end
  endtask

  task automatic step(input bit r, input bit fv, input bit fs, input logic [31:0] fpc,
                      input bit uv, input logic [31:0] upc, input bit ut, input logic [31:0] utgt);
    rst = r; fetch_valid = fv; fetch_stall = fs; fetch_pc = fpc;
    update_valid = uv; update_pc = upc; update_taken = ut; update_target = utgt;
    @(posedge clk);
    model_edge();
    #1;
    chk("valid",  32'(predict_valid), 32'(p_valid));
    chk("hit",    32'(predict_hit),   32'(p_hit));
    chk("taken",  32'(predict_taken), 32'(p_taken));
    chk("target", predict_target,     p_target);
  endtask

  task automatic lookup(input logic [31:0] pc);
    step(0, 1, 0, pc, 0, 0, 0, 0);
  endtask

  task automatic train(input logic [31:0] pc, input bit t, input logic [31:0] tgt);
    step(0, 0, 0, 0, 1, pc, t, tgt);
  endtask

  task automatic expect_pred(input string tag, input bit v, input bit h, input bit t,
                             input logic [31:0] tgt);
    chk({tag, "_v"},   32'(predict_valid), 32'(v));
    chk({tag, "_h"},   32'(predict_hit),   32'(h));
    chk({tag, "_t"},   32'(predict_taken), 32'(t));
    chk({tag, "_tgt"}, predict_target,     tgt);
  endtask

  initial begin
    step(1, 1, 0, 32'h100, 1, 32'h100, 1, 32'h55);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    expect_pred("reset", 0, 0, 0, 0);

    lookup(32'h100);
    expect_pred("cold_miss", 1, 0, 0, 0);

    train(32'h100, 1, 32'h200);
    lookup(32'h100);
    expect_pred("alloc", 1, 1, 1, 32'h200);
    train(32'h100, 0, 0);
    train(32'h100, 0, 0);
    lookup(32'h100);
    expect_pred("dec_to_snt", 1, 1, 0, 32'h200);
    train(32'h100, 0, 0);
    train(32'h100, 1, 32'h200);
    lookup(32'h100);
    expect_pred("sat_low", 1, 1, 0, 32'h200);

    repeat (4) train(32'h100, 1, 32'h200);
    train(32'h100, 0, 0);
    lookup(32'h100);
    expect_pred("sat_high", 1, 1, 1, 32'h200);

    train(32'h1100, 1, 32'h300);
    lookup(32'h100);
    expect_pred("alias_old", 1, 0, 0, 0);
    lookup(32'h1103);
    expect_pred("alias_new", 1, 1, 1, 32'h300);

    train(32'h140, 0, 32'h999);
    lookup(32'h140);
    expect_pred("miss_nt", 1, 0, 0, 0);

    step(0, 1, 0, 32'h180, 1, 32'h180, 1, 32'h400);
    expect_pred("bypass", 1, 1, 1, 32'h400);
    step(0, 1, 1, 32'h1C0, 0, 0, 0, 0);
    expect_pred("stall_hold", 1, 1, 1, 32'h400);
    step(0, 0, 1, 32'h0, 0, 0, 0, 0);
    expect_pred("stall_hold2", 1, 1, 1, 32'h400);

    step(1, 1, 0, 32'h180, 0, 0, 0, 0);
    expect_pred("mid_reset", 0, 0, 0, 0);
    lookup(32'h180);
    expect_pred("post_reset", 1, 0, 0, 0);

    step(0, 0, 0, 0, 0, 0, 0, 0);
    expect_pred("idle", 0, 0, 0, 0);

    // Small tag/index pool so hits, aliasing and same-index bypass all occur.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] fpc, upc, tgt;
      fpc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) upc = fpc;
      tgt = $urandom;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
           fpc, $urandom_range(0, 2) != 0, upc, $urandom_range(0, 1) == 1, tgt);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
